// File: rtl/traffic_pkg.sv
// Shared types and default timing for the four-road traffic light controller.
package traffic_pkg;

    localparam int unsigned NUM_ROADS        = 4;
    localparam int unsigned DEF_GREEN_TIME   = 10;
    localparam int unsigned DEF_ORANGE_TIME  = 3;
    localparam int unsigned DEF_ALLRED_TIME  = 1;

    typedef logic [1:0] road_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        ORANGE = 2'd2,
        ALLRED = 2'd3
    } state_t;

    // Timer only counts up to (longest phase - 1), so this many bits never wrap.
    function automatic int unsigned timer_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority road selector: first requester after cur, cur itself last.
module rr_pick
    import traffic_pkg::*;
(
    input  logic [NUM_ROADS-1:0] req,
    input  road_t                cur,
    output logic                 valid,
    output road_t                idx
);

    road_t cand;

    always_comb begin
        valid = 1'b0;
        idx   = cur;
        cand  = cur;
        for (int k = 1; k <= 4; k++) begin
            cand = road_t'(cur + road_t'(k));
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/main_module.sv
// Four-road traffic light controller with minimum green, orange, all-red clearance
// and round-robin service of vehicle sensors.
module main_module
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TIME  = DEF_GREEN_TIME,
    parameter int unsigned ORANGE_TIME = DEF_ORANGE_TIME,
    parameter int unsigned ALLRED_TIME = DEF_ALLRED_TIME
) (
    output logic R1,
    output logic O1,
    output logic G1,
    output logic R2,
    output logic O2,
    output logic G2,
    output logic R3,
    output logic O3,
    output logic G3,
    output logic R4,
    output logic O4,
    output logic G4,
    input  logic t1,
    input  logic t2,
    input  logic t3,
    input  logic t4,
    input  logic clk,
    input  logic reset
);

    localparam int unsigned TW = timer_width(GREEN_TIME, ORANGE_TIME, ALLRED_TIME);
    localparam logic [TW-1:0] G_LAST  = TW'(GREEN_TIME - 1);
    localparam logic [TW-1:0] O_LAST  = TW'(ORANGE_TIME - 1);
    localparam logic [TW-1:0] AR_LAST = TW'((ALLRED_TIME == 0) ? 0 : ALLRED_TIME - 1);

    state_t                state_q, state_d;
    road_t                 cur_q, cur_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_ROADS-1:0]  r_q, o_q, g_q;
    logic [NUM_ROADS-1:0]  r_d, o_d, g_d;

    logic [NUM_ROADS-1:0]  req;
    logic                  pick_valid;
    road_t                 pick_idx;
    logic                  others;
    logic                  own;

    assign req    = {t4, t3, t2, t1};
    assign others = |(req & ~(NUM_ROADS'(1) << cur_q));
    assign own    = req[cur_q];

    rr_pick u_pick (
        .req   (req),
        .cur   (cur_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= road_t'(3);
            timer_q <= '0;
            r_q     <= '1;
            o_q     <= '0;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            timer_q <= timer_d;
            r_q     <= r_d;
            o_q     <= o_d;
            g_q     <= g_d;
        end
    end

    // Next state; lamps are decoded from the next state so they change with it.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        timer_d = TW'(timer_q + 1'b1);
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_valid) begin
                    cur_d   = pick_idx;
                    state_d = GREEN;
                end
            end
            GREEN: begin
                if (timer_q == G_LAST) begin
                    timer_d = '0;
                    if (!others && own) state_d = GREEN;
                    else                state_d = ORANGE;
                end
            end
            ORANGE: begin
                if (timer_q == O_LAST) begin
                    timer_d = '0;
                    if (ALLRED_TIME != 0) begin
                        state_d = ALLRED;
                    end else if (pick_valid) begin
                        cur_d   = pick_idx;
                        state_d = GREEN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ALLRED: begin
                if (timer_q == AR_LAST) begin
                    timer_d = '0;
                    if (pick_valid) begin
                        cur_d   = pick_idx;
                        state_d = GREEN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        r_d = '1;
        o_d = '0;
        g_d = '0;
        if (state_d == GREEN) begin
            r_d[cur_d] = 1'b0;
            g_d[cur_d] = 1'b1;
        end else if (state_d == ORANGE) begin
            r_d[cur_d] = 1'b0;
            o_d[cur_d] = 1'b1;
        end
    end

    assign R1 = r_q[0];
    assign O1 = o_q[0];
    assign G1 = g_q[0];
    assign R2 = r_q[1];
    assign O2 = o_q[1];
    assign G2 = g_q[1];
    assign R3 = r_q[2];
    assign O3 = o_q[2];
    assign G3 = g_q[2];
    assign R4 = r_q[3];
    assign O4 = o_q[3];
    assign G4 = g_q[3];

endmodule

// File: tb/tb_main_module.sv
// Directed, table-driven bench for the traffic light controller.
module tb_main_module;

    logic clk;
    logic reset;
    logic t1, t2, t3, t4;
    logic R1, O1, G1, R2, O2, G2, R3, O3, G3, R4, O4, G4;

    int chk_cnt;
    int pass_cnt;
    bit mon_en;

    localparam int AR = 0;
    localparam int GR = 1;
    localparam int OR = 2;

    typedef struct {
        bit       rst;
        bit [3:0] t;
        int       adv;
        int       kind;
        int       road;
    } vec_t;

    vec_t tab[$];

    main_module dut (
        .R1(R1), .O1(O1), .G1(G1),
        .R2(R2), .O2(O2), .G2(G2),
        .R3(R3), .O3(O3), .G3(G3),
        .R4(R4), .O4(O4), .G4(G4),
        .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .clk(clk), .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] lamps_now();
        return {R1, O1, G1, R2, O2, G2, R3, O3, G3, R4, O4, G4};
    endfunction

    // Expected lamp pattern: one road green/orange, all others red.
    function automatic logic [11:0] expect_lamps(int kind, int road);
        logic [11:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            if (kind != AR && i == road) e[11-3*i -: 3] = (kind == GR) ? 3'b001 : 3'b010;
            else                         e[11-3*i -: 3] = 3'b100;
        end
        return e;
    endfunction

    task automatic check(string name, logic [11:0] exp_l);
        logic [11:0] act;
        act = lamps_now();
        chk_cnt++;
        if (act === exp_l) pass_cnt++;
        else $display("FAIL %s: lamps=%b expected=%b at %0t", name, act, exp_l, $time);
    endtask

    // Per-road one-hot lamps and at most one road non-red, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [11:0] l;
            int nonred;
            bit ok;
            l = lamps_now();
            ok = 1'b1;
            nonred = 0;
            for (int i = 0; i < 4; i++) begin
                logic [2:0] rog;
                rog = l[11-3*i -: 3];
                if (!(rog == 3'b100 || rog == 3'b010 || rog == 3'b001)) ok = 1'b0;
                if (rog != 3'b100) nonred++;
            end
            if (nonred > 1) ok = 1'b0;
            chk_cnt++;
            if (ok) pass_cnt++;
            else $display("FAIL invariant: lamps=%b nonred=%0d at %0t", l, nonred, $time);
        end
    end

    task automatic set_t(bit [3:0] v);
        {t4, t3, t2, t1} = v;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        mon_en   = 1'b0;
        reset    = 1'b0;
        set_t(4'h0);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Scenario 1: all sensors high, service order 1,2,3,4,1 with 14-cycle period
        tab.push_back('{1'b1, 4'hF, 1,  GR, 0});
        tab.push_back('{1'b0, 4'hF, 9,  GR, 0});
        tab.push_back('{1'b0, 4'hF, 1,  OR, 0});
        tab.push_back('{1'b0, 4'hF, 2,  OR, 0});
        tab.push_back('{1'b0, 4'hF, 1,  AR, 0});
        tab.push_back('{1'b0, 4'hF, 1,  GR, 1});
        tab.push_back('{1'b0, 4'hF, 13, AR, 0});
        tab.push_back('{1'b0, 4'hF, 1,  GR, 2});
        tab.push_back('{1'b0, 4'hF, 14, GR, 3});
        tab.push_back('{1'b0, 4'hF, 14, GR, 0});
        // Scenario 2: only t3, green extended in 10-cycle blocks, then drop
        tab.push_back('{1'b1, 4'h4, 1,  GR, 2});
        tab.push_back('{1'b0, 4'h4, 9,  GR, 2});
        tab.push_back('{1'b0, 4'h4, 1,  GR, 2});
        tab.push_back('{1'b0, 4'h4, 14, GR, 2});
        tab.push_back('{1'b0, 4'h0, 5,  GR, 2});
        tab.push_back('{1'b0, 4'h0, 1,  OR, 2});
        tab.push_back('{1'b0, 4'h0, 2,  OR, 2});
        tab.push_back('{1'b0, 4'h0, 1,  AR, 0});
        tab.push_back('{1'b0, 4'h0, 5,  AR, 0});
        // Scenario 3: no sensors, then t4 gives G4 on the next edge
        tab.push_back('{1'b1, 4'h0, 1,  AR, 0});
        tab.push_back('{1'b0, 4'h0, 20, AR, 0});
        tab.push_back('{1'b0, 4'h8, 1,  GR, 3});
        // Scenario 4: t1 drops early, green still runs full length
        tab.push_back('{1'b1, 4'hF, 1,  GR, 0});
        tab.push_back('{1'b0, 4'hF, 1,  GR, 0});
        tab.push_back('{1'b0, 4'hE, 8,  GR, 0});
        tab.push_back('{1'b0, 4'hE, 1,  OR, 0});
        tab.push_back('{1'b0, 4'hE, 3,  AR, 0});
        tab.push_back('{1'b0, 4'hE, 1,  GR, 1});
        // Scenario 5 lead-in: run to the middle of O2
        tab.push_back('{1'b1, 4'hF, 1,  GR, 0});
        tab.push_back('{1'b0, 4'hF, 25, OR, 1});

        foreach (tab[i]) begin
            set_t(tab[i].t);
            if (tab[i].rst) begin
                reset = 1'b0;
                #1;
                check($sformatf("vec%0d_reset", i), expect_lamps(AR, 0));
                #1;
                reset = 1'b1;
            end
            repeat (tab[i].adv) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), expect_lamps(tab[i].kind, tab[i].road));
        end

        // Scenario 5: reset in the high phase of clk during O2 clears lamps at once
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_orange", expect_lamps(AR, 0));
        @(negedge clk);
        check("reset_held", expect_lamps(AR, 0));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_g1", expect_lamps(GR, 0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("restart_o1", expect_lamps(OR, 0));

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/main_module.md
MAIN_MODULE -- requirements
Module: main_module

Interface
REQ-001 Parameter GREEN_TIME, default 10, minimum green duration in clock cycles.
REQ-002 Parameter ORANGE_TIME, default 3, orange duration in clock cycles.
REQ-003 Parameter ALLRED_TIME, default 1, all-red clearance duration in clock cycles.
REQ-004 clk  input  1  system clock, 1 Hz nominal; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 t1..t4  input  1 each  vehicle-present sensor for roads 1..4; 1 = vehicle waiting.
REQ-007 R1,O1,G1 .. R4,O4,G4  output  1 each  red/orange/green lamp for roads 1..4.
REQ-008 Port order SHALL be R1,O1,G1,R2,O2,G2,R3,O3,G3,R4,O4,G4,t1,t2,t3,t4,clk,reset.

Function
REQ-009 Outputs SHALL be registered Moore outputs, driven by the state register and the current-road pointer cur (2 bits).
REQ-010 Each road SHALL have exactly one of R/O/G high at all times.
REQ-011 At most one road SHALL be non-red at any time; all other roads show R=1.
REQ-012 States SHALL be IDLE, GREEN, ORANGE and ALLRED; a cycle timer counts cycles spent in the current state.
REQ-013 IDLE: all roads red; each cycle, select the first road with its sensor high, searching cur+1, cur+2, cur+3, cur (mod 4); on a hit, load cur, clear the timer and enter GREEN; otherwise stay in IDLE.
REQ-014 GREEN: G(cur)=1; on completing GREEN_TIME cycles:
  - any other sensor high -> enter ORANGE;
  - else own sensor high -> restart the timer and stay in GREEN;
  - else -> enter ORANGE.
REQ-015 Sensor changes during GREEN SHALL NOT shorten the green below GREEN_TIME.
REQ-016 ORANGE: O(cur)=1 for ORANGE_TIME cycles, then enter ALLRED.
REQ-017 ALLRED: all red for ALLRED_TIME cycles, then behave as IDLE selection (REQ-013) in the same transition; if no hit, enter IDLE.
REQ-018 Rotating priority SHALL start after cur, so every requesting road is served within 3 other service periods.
REQ-019 With ALLRED_TIME=0, ORANGE SHALL go directly to selection.
REQ-020 Timer width SHALL be sufficient for max(GREEN_TIME, ORANGE_TIME, ALLRED_TIME); no wrap-around within a state.

Reset
REQ-021 reset=0 SHALL immediately force state=IDLE, cur=3, timer=0, all R=1, all O=0, all G=0, independent of clk.
REQ-022 Reset asserted mid-cycle (any state) SHALL abort the phase; after release, operation restarts per REQ-013, with road 1 at highest priority.

Structure
REQ-023 The state encoding, default timing constants and road-index type SHALL live in a shared package, traffic_pkg.
REQ-024 The rotating-priority selector SHALL be one combinational sub-module, rr_pick: inputs 4-bit request vector and 2-bit cur; outputs valid and 2-bit index.
REQ-025 Lamp decoding SHALL be combinational from the registered state and cur, or the lamps SHALL be registered directly; there SHALL be no glitch path from the t inputs to the lamps.

Verification
REQ-026 Scenario 1: reset low, then released with all t=1 -> IDLE for 1 cycle; G1 for cycles 1-10; O1 for 11-13; all red at 14; G2 from 15; order 1,2,3,4,1 with a 14-cycle period.
REQ-027 Scenario 2: only t3=1 -> G3 is held indefinitely in 10-cycle extensions with no orange; t3 drops -> at the end of the current 10-cycle block, O3 for 3 cycles, all red, then IDLE.
REQ-028 Scenario 3: all t=0 -> all R=1 indefinitely; t4 rises -> G4 on the next rising edge.
REQ-029 Scenario 4: G1 active and t1 drops after 2 cycles -> G1 still lasts the full 10 cycles, then orange, then the next requester.
REQ-030 Scenario 5: reset asserted during O2 -> all lamps red immediately (before the next clk edge); after release with all t=1 -> G1 first.
REQ-031 Scenario 6: every cycle, check the one-hot lamp invariant per road and that at most one road is non-red.
